iitb_mem_port_arbiter: RTL
==========================

// Module: iitb_mem_port_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data memory of the IITB_RISC pipeline between the IF stage and the MEM stage.
//  Sequences LW/SW as single beats and LM/SM as multi-beat bursts driven by an 8-bit register mask.
//  Stalls instruction fetch while data traffic owns the port.
// PARAMETERS
//  AW          16  memory address width (wraps mod 2^AW)
//  DW          16  memory data width
//  STARVE_MAX  4   consecutive denied fetch cycles before guard fires (IITB_MEMARB_STARVE_GUARD_EN only)
// PORTS
//  clk1         in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  if_req       in   1   fetch request
//  if_addr      in   AW  fetch address (PC)
//  if_gnt       out  1   fetch issued this cycle (combinational)
//  if_rvalid    out  1   fetch data valid (registered)
//  if_rdata     out  DW  fetched instruction
//  dm_req       in   1   data request; held until dm_gnt
//  dm_we        in   1   1=store (SW/SM), 0=load (LW/LM)
//  dm_multi     in   1   1=LM/SM burst using dm_mask; 0=single beat using dm_reg
//  dm_mask      in   8   LM/SM register mask, bit k = Rk
//  dm_reg       in   3   LW/SW register index
//  dm_addr      in   AW  base address
//  dm_gnt       out  1   data request accepted (combinational)
//  dm_sidx      out  3   register index of beat being issued (store data select)
//  dm_sdata     in   DW  register-file data for dm_sidx, same cycle
//  dm_beat_valid out 1   one beat completed (registered)
//  dm_beat_reg  out  3   register index of completed beat
//  dm_rdata     out  DW  load data for completed beat
//  dm_done      out  1   one-cycle pulse: whole request complete
//  dm_busy      out  1   arbiter in DATA state
//  mem_en, mem_we  out  1  memory strobe / write enable
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  synchronous-read data, valid 1 cycle after mem_en&!mem_we
// BEHAVIOUR
//  Reset: state=IDLE, pending mask=0, beat count=0, starve count=0; if_rvalid, dm_beat_valid, dm_done, dm_busy=0.
//   Combinational outputs: mem_en=0, if_gnt=0, dm_gnt=0.
//   Reset mid-burst aborts silently; no dm_done is issued.
//  IDLE: dm_req=1 -> dm_gnt=1, latch we/addr/mask (single: mask=1<<dm_reg), beat count=0, go DATA.
//   No memory access in the accept cycle.
//   Else if_req=1 -> if_gnt=1, mem_en=1, mem_addr=if_addr; if_rvalid/if_rdata next cycle.
//  Simultaneous dm_req & if_req in IDLE: data wins; if_gnt=0.
//  DATA: each cycle issue the lowest set bit k of the pending mask.
//   mem_addr = base + beat count (mod 2^AW); dm_sidx = k; mem_we = we; mem_wdata = dm_sdata.
//   Then clear bit k and increment beat count.
//   Consecutive set bits map to consecutive addresses, regardless of gaps in the mask.
//   dm_gnt=0 and if_gnt=0 while in DATA; dm_req is ignored.
//  Beat completion: cycle after issue, dm_beat_valid=1, dm_beat_reg=k; dm_rdata=mem_rdata for loads.
//   dm_beat_valid is also asserted for stores (as write acknowledge).
//  dm_done pulses together with the last beat's dm_beat_valid; state returns to IDLE in that same cycle.
//   The next request (data or fetch) may therefore issue back-to-back.
//  Empty LM/SM mask (dm_multi=1, dm_mask=0): no memory access; dm_done pulses the cycle after dm_gnt; dm_beat_valid stays 0.
//  Latency: LW accepted at T -> issued T+1 -> dm_rdata/dm_done at T+2. N-beat burst -> done at T+1+N.
//  if_rvalid and dm_beat_valid are never both 1 in the same cycle.
//  dm_busy = (state==DATA).
// CONFIGURATION
//  IITB_MEMARB_STARVE_GUARD_EN defined:
//   In DATA, count cycles with if_req=1 and if_gnt=0.
//   When count >= STARVE_MAX and if_req=1, that cycle issues the fetch (if_gnt=1) instead of a data beat.
//   The count then clears; the burst resumes next cycle, so the data sequence is delayed by 1 cycle.
//   Beat order and addresses are unchanged.
//  Not defined: counter absent; bursts are never interrupted; fetch waits until IDLE.
// TESTING
//  1 Fetch only, Mem[0]=16'h0050, if_req, if_addr=0 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=16'h0050.
//  2 LW dm_reg=3 addr=26 (Mem[26]=5000), if_req held -> dm_gnt at T, if_gnt=0 T..T+1.
//    At T+2: dm_beat_reg=3, dm_rdata=5000, dm_done=1, if_gnt=1.
//  3 LM addr=26 mask=8'b00000101 (Mem[27]=5001) -> beats R0=5000 (T+2), R2=5001 (T+3); dm_done at T+3 only.
//  4 SM addr=16'hFFFF mask=8'b10000001, sdata=Rk -> Mem[FFFF]=R0, Mem[0000]=R7 (address wrap); two acks, one done.
//  5 LM mask=0 -> dm_done at T+1, no mem_en, no dm_beat_valid.
//    Then assert rst_n=0 mid 8-beat LM -> all outputs 0 asynchronously, no dm_done after release.
//  6 Guard on, STARVE_MAX=4, 8-beat LM with if_req held -> one fetch inserted after 4 denied cycles.
//    dm_done slips 1 cycle. Guard off: no fetch until done.

Source files
------------

// File: rtl/iitb_mem_port_arbiter.sv
// IITB_RISC unified-memory port arbiter: IF fetches vs MEM-stage LW/SW/LM/SM beats (data wins).
// Optional fetch-starvation guard enabled by defining IITB_MEMARB_STARVE_GUARD_EN.
module iitb_mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic          dm_multi,
  input  logic [7:0]    dm_mask,
  input  logic [2:0]    dm_reg,
  input  logic [AW-1:0] dm_addr,
  output logic          dm_gnt,
  output logic [2:0]    dm_sidx,
  input  logic [DW-1:0] dm_sdata,
  output logic          dm_beat_valid,
  output logic [2:0]    dm_beat_reg,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t        state_q;
  logic          we_q;
  logic [AW-1:0] base_q;
  logic [7:0]    pend_q;
  logic [3:0]    cnt_q;
  logic          if_rvalid_q;
  logic          bv_q;
  logic [2:0]    breg_q;
  logic          bwe_q;
  logic          done_q;

  logic [2:0]    low_idx;
  logic [7:0]    pend_clr;
  logic [7:0]    accept_mask;
  logic          beat_go;
  logic          guard_fire;

  always_comb begin
    low_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (pend_q[k]) low_idx = 3'(k);
    end
  end

  assign pend_clr    = pend_q & (pend_q - 8'd1);
  assign accept_mask = dm_multi ? dm_mask : (8'd1 << dm_reg);

`ifdef IITB_MEMARB_STARVE_GUARD_EN
  localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] starve_q;

  assign guard_fire = (state_q == S_DATA) && if_req && (starve_q >= SCW'(STARVE_MAX));

  // Counts denied fetch cycles only while a data request owns the port.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (state_q != S_DATA || guard_fire) begin
      starve_q <= '0;
    end else if (if_req) begin
      starve_q <= starve_q + SCW'(1);
    end
  end
`else
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
  assign guard_fire        = 1'b0;
`endif

  // Port strobes are gated by rst_n so reset silences the memory immediately.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    beat_go   = 1'b0;
    if (rst_n) begin
      if (state_q == S_IDLE) begin
        if (dm_req) begin
          dm_gnt = 1'b1;
        end else if (if_req) begin
          if_gnt   = 1'b1;
          mem_en   = 1'b1;
          mem_addr = if_addr;
        end
      end else if (guard_fire) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end else if (pend_q != 8'd0) begin
        beat_go  = 1'b1;
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = base_q + AW'(cnt_q);
        if (we_q) mem_wdata = dm_sdata;
      end
    end
  end

  assign dm_sidx = low_idx;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      base_q      <= '0;
      pend_q      <= 8'd0;
      cnt_q       <= 4'd0;
      if_rvalid_q <= 1'b0;
      bv_q        <= 1'b0;
      breg_q      <= 3'd0;
      bwe_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if_rvalid_q <= if_gnt;
      bv_q        <= beat_go;
      breg_q      <= low_idx;
      bwe_q       <= we_q;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dm_req) begin
            we_q   <= dm_we;
            base_q <= dm_addr;
            pend_q <= accept_mask;
            cnt_q  <= 4'd0;
            // An empty LM/SM mask completes without ever owning the port.
            if (accept_mask == 8'd0) done_q  <= 1'b1;
            else                     state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_go) begin
            pend_q <= pend_clr;
            cnt_q  <= cnt_q + 4'd1;
            if (pend_clr == 8'd0) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_rvalid     = if_rvalid_q;
  assign if_rdata      = if_rvalid_q ? mem_rdata : '0;
  assign dm_beat_valid = bv_q;
  assign dm_beat_reg   = breg_q;
  assign dm_rdata      = (bv_q && !bwe_q) ? mem_rdata : '0;
  assign dm_done       = done_q;
  assign dm_busy       = (state_q == S_DATA);

endmodule
